// File: rtl/pin_synch.sv
// -----------------------------------------------------------------------------
// pin_synch
//
// Multi-channel conditioner for asynchronous input pins. Every channel runs
// through its own synchroniser chain, an optional glitch filter and a
// registered edge detector.
//
// Build option:
//   PIN_SYNCH_FILTER_EN  defined   -> per-channel persistence counters are
//                                     built. A new synchronised value must
//                                     persist for FILTER cycles before it
//                                     reaches pinOut.
//                        undefined -> no counters. pinOut registers the
//                                     synchroniser output on every
//                                     non-frozen cycle, and FILTER is unused.
//
// Parameters:
//   WIDTH   number of independent channels (>= 1)
//   STAGES  synchroniser flop depth (>= 2)
//   FILTER  persistence cycles needed to accept a new value (>= 1)
//   RST_VAL per-channel reset level for the chain flops and pinOut
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset, has priority over frz
//   pinIn    raw asynchronous pin levels
//   frz      freeze: holds pinOut and the counters and forces the pulses low.
//            The sync chain keeps shifting. frz is already in the clk domain.
//   pinOut   filtered, synchronised levels
//   pinRise  one-cycle pulse in the first cycle pinOut[i] shows 1
//   pinFall  one-cycle pulse in the first cycle pinOut[i] shows 0
// -----------------------------------------------------------------------------
module pin_synch #(
  parameter int               WIDTH   = 3,
  parameter int               STAGES  = 2,
  parameter int               FILTER  = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pinIn,
  input  logic             frz,
  output logic [WIDTH-1:0] pinOut,
  output logic [WIDTH-1:0] pinRise,
  output logic [WIDTH-1:0] pinFall
);

  // Reject unusable parameter sets during elaboration.
  if (WIDTH < 1 || STAGES < 2 || FILTER < 1) begin : gBadParams
    $error("pin_synch: WIDTH>=1, STAGES>=2 and FILTER>=1 are required");
  end

  // Synchroniser chain. Stage 0 samples the pins, and the last stage is the
  // first value that can be trusted in the clk domain.
  logic [WIDTH-1:0] chainReg [STAGES];
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        chainReg[s] <= RST_VAL;
      end
    end else begin
      chainReg[0] <= pinIn;
      for (int s = 1; s < STAGES; s++) begin
        chainReg[s] <= chainReg[s-1];
      end
    end
  end

  assign sync = chainReg[STAGES-1];

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : gCh
    logic outReg;
    logic riseReg;
    logic fallReg;

`ifdef PIN_SYNCH_FILTER_EN
    localparam int CW = $clog2(FILTER + 1);

    logic [CW-1:0] cntReg;
    logic          differ;
    logic          accept;

    // The counter value reaches FILTER on the same edge that a persistent
    // difference is accepted. That value is never stored: the counter clears
    // on that edge instead.
    assign differ = sync[gi] != outReg;
    assign accept = differ && (cntReg == CW'(FILTER - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        cntReg  <= '0;
        outReg  <= RST_VAL[gi];
        riseReg <= 1'b0;
        fallReg <= 1'b0;
      end else if (frz) begin
        riseReg <= 1'b0;
        fallReg <= 1'b0;
      end else begin
        riseReg <= accept & sync[gi];
        fallReg <= accept & ~sync[gi];
        if (accept) begin
          outReg <= sync[gi];
        end
        // Equality, or an accepted change, discards any partial count.
        if (!differ || accept) begin
          cntReg <= '0;
        end else begin
          cntReg <= cntReg + CW'(1);
        end
      end
    end
`else
    logic differ;

    assign differ = sync[gi] != outReg;

    always_ff @(posedge clk) begin
      if (rst) begin
        outReg  <= RST_VAL[gi];
        riseReg <= 1'b0;
        fallReg <= 1'b0;
      end else if (frz) begin
        riseReg <= 1'b0;
        fallReg <= 1'b0;
      end else begin
        outReg  <= sync[gi];
        riseReg <= differ & sync[gi];
        fallReg <= differ & ~sync[gi];
      end
    end
`endif

    assign pinOut[gi]  = outReg;
    assign pinRise[gi] = riseReg;
    assign pinFall[gi] = fallReg;
  end

endmodule

// File: tb/tb_pin_synch.sv
// -----------------------------------------------------------------------------
// tb_pin_synch
//
// Self-checking bench for pin_synch (WIDTH=3, STAGES=2, FILTER=4,
// RST_VAL=3'b010). It adapts to PIN_SYNCH_FILTER_EN: with the filter compiled
// out, the bench treats the filter as accepting a change after one cycle.
//
// The reference model keeps a history of the sampled pin values and a count of
// how many non-frozen cycles each channel has disagreed with its output.
// -----------------------------------------------------------------------------
module tb_pin_synch;

  localparam int         WIDTH   = 3;
  localparam int         STAGES  = 2;
  localparam int         FILTER  = 4;
  localparam logic [2:0] RST_VAL = 3'b010;
`ifdef PIN_SYNCH_FILTER_EN
  localparam int FEFF = FILTER;
`else
  localparam int FEFF = 1;
`endif
  // Number of edges after the first sampling edge at which pinOut changes.
  localparam int LATE = STAGES - 1 + FEFF;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pinIn;
  logic             frz;
  logic [WIDTH-1:0] pinOut;
  logic [WIDTH-1:0] pinRise;
  logic [WIDTH-1:0] pinFall;

  int checks   = 0;
  int failures = 0;

  pin_synch #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .FILTER (FILTER),
    .RST_VAL(RST_VAL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pinIn  (pinIn),
    .frz    (frz),
    .pinOut (pinOut),
    .pinRise(pinRise),
    .pinFall(pinFall)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mHist [STAGES];   // mHist[k]: pin value sampled k+1 edges ago
  logic [WIDTH-1:0] mOut, mRise, mFall;
  int               mRun [WIDTH];

  always @(posedge clk) begin : modelBlk
    logic [WIDTH-1:0] settled;
    logic [WIDTH-1:0] nOut, nRise, nFall;
    logic [WIDTH-1:0] nHist [STAGES];
    int               nRun [WIDTH];
    settled = mHist[STAGES-1];
    nOut  = mOut;
    nRise = '0;
    nFall = '0;
    for (int c = 0; c < WIDTH; c++) nRun[c] = mRun[c];
    if (rst) begin
      for (int s = 0; s < STAGES; s++) nHist[s] = RST_VAL;
      nOut = RST_VAL;
      for (int c = 0; c < WIDTH; c++) nRun[c] = 0;
    end else begin
      nHist[0] = pinIn;
      for (int s = 1; s < STAGES; s++) nHist[s] = mHist[s-1];
      if (!frz) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (settled[c] != mOut[c]) begin
            nRun[c] = mRun[c] + 1;
            if (nRun[c] == FEFF) begin
              nOut[c] = settled[c];
              nRun[c] = 0;
              if (settled[c]) nRise[c] = 1'b1;
              else            nFall[c] = 1'b1;
            end
          end else begin
            nRun[c] = 0;
          end
        end
      end
    end
    for (int s = 0; s < STAGES; s++) mHist[s] <= nHist[s];
    for (int c = 0; c < WIDTH; c++) mRun[c] <= nRun[c];
    mOut  <= nOut;
    mRise <= nRise;
    mFall <= nFall;
  end

  // Wait n cycles without checking; used to let the pins settle.
  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [2:0] expOut, expRise, expFall;
    $display("test_reset: pinIn=101 held through reset, RST_VAL=010");
    rst = 1'b1; frz = 1'b0; pinIn = 3'b101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (pinOut !== RST_VAL || pinRise !== 3'b000 || pinFall !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold i=%0d out=%b rise=%b fall=%b required out=%b rise=000 fall=000",
                 i, pinOut, pinRise, pinFall, RST_VAL);
      end
    end
    rst = 1'b0;
    for (int j = 0; j <= LATE + 1; j++) begin
      @(negedge clk);
      expOut  = (j >= LATE) ? 3'b101 : RST_VAL;
      expRise = (j == LATE) ? 3'b101 : 3'b000;
      expFall = (j == LATE) ? 3'b010 : 3'b000;
      checks++;
      if (pinOut !== expOut || pinRise !== expRise || pinFall !== expFall) begin
        failures++;
        $display("FAIL reset_release j=%0d out=%b rise=%b fall=%b required out=%b rise=%b fall=%b",
                 j, pinOut, pinRise, pinFall, expOut, expRise, expFall);
      end
      checks++;
      if (pinOut !== mOut || pinRise !== mRise || pinFall !== mFall) begin
        failures++;
        $display("FAIL reset_model j=%0d out=%b/%b rise=%b/%b fall=%b/%b (actual/required)",
                 j, pinOut, mOut, pinRise, mRise, pinFall, mFall);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_latency();
    $display("test_latency: pinIn[0] 0->1, expect change after %0d edges", LATE);
    pinIn = 3'b100;
    settle(LATE + 4);
    pinIn[0] = 1'b1;
    for (int j = 0; j <= LATE + 1; j++) begin
      @(negedge clk);
      checks++;
      if (pinOut[0] !== (j >= LATE) || pinRise[0] !== (j == LATE) || pinFall[0] !== 1'b0) begin
        failures++;
        $display("FAIL latency j=%0d out0=%b rise0=%b fall0=%b required out0=%b rise0=%b fall0=0",
                 j, pinOut[0], pinRise[0], pinFall[0], (j >= LATE), (j == LATE));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_glitch();
    int  widths [2] = '{3, 4};
    logic accepted, eOut, eRise, eFall;
    for (int k = 0; k < 2; k++) begin
      int w;
      w = widths[k];
      accepted = (w >= FEFF);
      $display("test_glitch: pinIn[1] pulse of %0d cycles, accepted=%0b", w, accepted);
      pinIn[1] = 1'b1;
      for (int j = 0; j <= LATE + w + 2; j++) begin
        @(negedge clk);
        eOut  = accepted && (j >= LATE) && (j < LATE + w);
        eRise = accepted && (j == LATE);
        eFall = accepted && (j == LATE + w);
        checks++;
        if (pinOut[1] !== eOut || pinRise[1] !== eRise || pinFall[1] !== eFall) begin
          failures++;
          $display("FAIL glitch w=%0d j=%0d out1=%b rise1=%b fall1=%b required out1=%b rise1=%b fall1=%b",
                   w, j, pinOut[1], pinRise[1], pinFall[1], eOut, eRise, eFall);
        end
        if (j == w - 1) pinIn[1] = 1'b0;
      end
      settle(2);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_freeze();
    $display("test_freeze: pinIn[2] rises while frozen for 10 cycles");
    pinIn[2] = 1'b0;
    settle(LATE + 4);
    frz = 1'b1;
    @(negedge clk);
    pinIn[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (pinOut[2] !== 1'b0 || pinRise !== 3'b000 || pinFall !== 3'b000) begin
        failures++;
        $display("FAIL freeze_hold i=%0d out2=%b rise=%b fall=%b required out2=0 rise=000 fall=000",
                 i, pinOut[2], pinRise, pinFall);
      end
    end
    frz = 1'b0;
    for (int j = 0; j <= FEFF + 1; j++) begin
      @(negedge clk);
      checks++;
      if (pinOut[2] !== (j >= FEFF - 1) || pinRise[2] !== (j == FEFF - 1) || pinFall[2] !== 1'b0) begin
        failures++;
        $display("FAIL freeze_resume j=%0d out2=%b rise2=%b fall2=%b required out2=%b rise2=%b fall2=0",
                 j, pinOut[2], pinRise[2], pinFall[2], (j >= FEFF - 1), (j == FEFF - 1));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mid_reset();
    logic [2:0] expOut, expRise, expFall;
    $display("test_mid_reset: reset lands on the accept edge of channel 0");
    pinIn = 3'b000;
    settle(LATE + 4);
    pinIn = 3'b001;
    for (int j = 0; j < LATE; j++) begin
      @(negedge clk);
      checks++;
      if (pinOut !== 3'b000 || pinRise !== 3'b000) begin
        failures++;
        $display("FAIL midrst_count j=%0d out=%b rise=%b required out=000 rise=000", j, pinOut, pinRise);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pinOut !== RST_VAL || pinRise !== 3'b000 || pinFall !== 3'b000) begin
      failures++;
      $display("FAIL midrst_reset out=%b rise=%b fall=%b required out=%b rise=000 fall=000",
               pinOut, pinRise, pinFall, RST_VAL);
    end
    rst = 1'b0;
    for (int k = 0; k <= LATE + 1; k++) begin
      @(negedge clk);
      expOut  = (k >= LATE) ? 3'b001 : RST_VAL;
      expRise = (k == LATE) ? 3'b001 : 3'b000;
      expFall = (k == LATE) ? 3'b010 : 3'b000;
      checks++;
      if (pinOut !== expOut || pinRise !== expRise || pinFall !== expFall) begin
        failures++;
        $display("FAIL midrst_restart k=%0d out=%b rise=%b fall=%b required out=%b rise=%b fall=%b",
                 k, pinOut, pinRise, pinFall, expOut, expRise, expFall);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    int flipOdds;
    $display("test_random: 800 cycles of random pins, freeze and reset");
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if (pinOut !== mOut || pinRise !== mRise || pinFall !== mFall) begin
        failures++;
        $display("FAIL random cyc=%0d out=%b/%b rise=%b/%b fall=%b/%b (actual/required)",
                 i, pinOut, mOut, pinRise, mRise, pinFall, mFall);
      end
      flipOdds = (i < 400) ? 3 : 9;
      for (int c = 0; c < WIDTH; c++) begin
        if ($urandom_range(0, flipOdds - 1) == 0) pinIn[c] = ~pinIn[c];
      end
      frz = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) == 0);
    end
    rst = 1'b0;
    frz = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frz = 1'b0;
    pinIn = 3'b101;
    test_reset();
    test_latency();
    test_glitch();
    test_freeze();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
